// File: rtl/cmd_decoder.sv
// cmd_decoder: parses opcode/argument byte packets into 16-bit line buffer writes.
// Defining CMDDEC_CLEAR_EN adds opcode 0x04 CLEAR, which writes CLEAR_VALUE to every line buffer word.
module cmd_decoder #(
  parameter int ADDR_BITS = 8
`ifdef CMDDEC_CLEAR_EN
  , parameter logic [15:0] CLEAR_VALUE = 16'h0000
`endif
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cmd_avail,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_rd,
  output logic                 lb_wr,
  output logic [ADDR_BITS-1:0] lb_wr_addr,
  output logic [15:0]          lb_wr_data,
  output logic                 busy,
  output logic                 err_op
);
  typedef enum logic [2:0] {
    S_OP, S_ADDR, S_CNT, S_HI, S_LO, S_FILL
`ifdef CMDDEC_CLEAR_EN
    , S_CLR
`endif
  } state_t;
  state_t state;
  logic [ADDR_BITS-1:0] addr;
  logic [8:0] count;
  logic [7:0] hi;
  logic fill;
  logic take;
  assign take = cmd_avail && !cmd_rd && (state inside {S_OP, S_ADDR, S_CNT, S_HI, S_LO});
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= S_OP;
      cmd_rd <= 1'b0;
      lb_wr <= 1'b0;
      lb_wr_addr <= '0;
      lb_wr_data <= '0;
      busy <= 1'b0;
      err_op <= 1'b0;
      addr <= '0;
      count <= '0;
      hi <= '0;
      fill <= 1'b0;
    end else begin
      cmd_rd <= take;
      lb_wr <= 1'b0;
      err_op <= 1'b0;
      case (state)
        S_OP: if (take) begin
          fill <= cmd_data == 8'h03;
          if (cmd_data == 8'h01) begin
            state <= S_ADDR;
            busy <= 1'b1;
          end else if (cmd_data == 8'h02 || cmd_data == 8'h03) begin
            state <= S_CNT;
            busy <= 1'b1;
          end
`ifdef CMDDEC_CLEAR_EN
          else if (cmd_data == 8'h04) begin
            state <= S_CLR;
            busy <= 1'b1;
            addr <= '0;
          end
`endif
          else if (cmd_data != 8'h00) err_op <= 1'b1;
        end
        S_ADDR: if (take) begin
          addr <= ADDR_BITS'(cmd_data);
          state <= S_OP;
          busy <= 1'b0;
        end
        S_CNT: if (take) begin
          count <= {cmd_data == 8'h00, cmd_data};
          state <= S_HI;
        end
        S_HI: if (take) begin
          hi <= cmd_data;
          state <= S_LO;
        end
        // the lo byte of a FILL pattern also issues the first fill word, keeping FILL latency equal to WRITE
        S_LO: if (take) begin
          lb_wr <= 1'b1;
          lb_wr_addr <= addr;
          lb_wr_data <= {hi, cmd_data};
          addr <= addr + 1'b1;
          count <= count - 1'b1;
          state <= count == 9'd1 ? S_OP : fill ? S_FILL : S_HI;
          busy <= count != 9'd1;
        end
        S_FILL: begin
          lb_wr <= 1'b1;
          lb_wr_addr <= addr;
          addr <= addr + 1'b1;
          count <= count - 1'b1;
          if (count == 9'd1) begin
            state <= S_OP;
            busy <= 1'b0;
          end
        end
`ifdef CMDDEC_CLEAR_EN
        S_CLR: begin
          lb_wr <= 1'b1;
          lb_wr_addr <= addr;
          lb_wr_data <= CLEAR_VALUE;
          addr <= addr + 1'b1;
          if (&addr) begin
            state <= S_OP;
            busy <= 1'b0;
          end
        end
`endif
        default: begin
          state <= S_OP;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: random and directed byte streams checked against a packet-level write model.
module tb_cmd_decoder;
  localparam int AW = 8;
  logic clk = 1'b0, nrst = 1'b0, cmd_avail = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_rd, lb_wr, busy, err_op;
  logic [AW-1:0] lb_wr_addr;
  logic [15:0] lb_wr_data;
  int total = 0, bad = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, m_addr = 0, m_err = 0;
  logic [23:0] exp_q[$];
  logic [23:0] e;
  bit mon_en = 1'b1, prev_rd = 1'b0;
  always #5 clk = ~clk;
  cmd_decoder #(.ADDR_BITS(AW)) dut (
    .clk(clk), .nrst(nrst), .cmd_avail(cmd_avail), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
    .lb_wr(lb_wr), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .busy(busy), .err_op(err_op)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (nrst) begin
    if (cmd_rd) begin
      rd_cnt++;
      check("rd_back_to_back", prev_rd, 0);
    end
    prev_rd = cmd_rd;
    if (err_op) err_cnt++;
    if (lb_wr) begin
      wr_cnt++;
      if (mon_en) begin
        check("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", lb_wr_addr, e[23:16]);
          check("wr_data", lb_wr_data, e[15:0]);
        end
      end
    end
  end
  task automatic model(input logic [7:0] s[$]);
    int i = 0, n;
    logic [7:0] op;
    logic [15:0] w = 16'h0;
    while (i < s.size()) begin
      op = s[i];
      i++;
      if (op == 8'h01) begin
        m_addr = s[i];
        i++;
      end else if (op == 8'h02 || op == 8'h03) begin
        n = s[i] == 8'h00 ? 256 : int'(s[i]);
        i++;
        for (int k = 0; k < n; k++) begin
          if (op == 8'h02 || k == 0) begin
            w = {s[i], s[i+1]};
            i += 2;
          end
          exp_q.push_back({m_addr[7:0], w});
          m_addr = (m_addr + 1) % 256;
        end
      end
`ifdef CMDDEC_CLEAR_EN
      else if (op == 8'h04) begin
        for (int a = 0; a < 256; a++) exp_q.push_back({a[7:0], 16'h0000});
        m_addr = 0;
      end
`endif
      else if (op != 8'h00) m_err++;
    end
  endtask
  task automatic feed(input logic [7:0] s[$], input int max_gap);
    int t;
    foreach (s[j]) begin
      if (max_gap > 0) begin
        cmd_avail = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      end
      cmd_data = s[j];
      cmd_avail = 1'b1;
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!cmd_rd && t < 2000);
      if (!cmd_rd) check("byte_accept_timeout", cmd_rd, 1);
    end
    cmd_avail = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    check("writes_outstanding", exp_q.size(), 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rd"}, cmd_rd, 0);
    check({tag, "_lb_wr"}, lb_wr, 0);
    check({tag, "_addr"}, lb_wr_addr, 0);
    check({tag, "_data"}, lb_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_op"}, err_op, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] s[$];
    int base, be, br, cyc, rdf, g, r, n;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(posedge clk); #1;
    // two-word WRITE after SET_ADDR
    s = '{8'h01, 8'h10, 8'h02, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    base = wr_cnt;
    model(s);
    feed(s, 0);
    drain();
    check("t1_write_count", wr_cnt - base, 2);
    check("t1_busy_idle", busy, 0);
    // 256-word FILL wrapping through address 0, offered a NOP throughout
    s = '{8'h01, 8'hFE, 8'h03, 8'h00, 8'h55, 8'hAA};
    base = wr_cnt;
    model(s);
    feed(s, 0);
    cmd_data = 8'h00;
    cmd_avail = 1'b1;
    cyc = 0;
    rdf = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() != 0 && cmd_rd) rdf++;
    end
    cmd_avail = 1'b0;
    check("t2_fill_cycles", cyc, 256);
    check("t2_rd_during_fill", rdf, 0);
    check("t2_write_count", wr_cnt - base, 256);
    drain();
    s = '{8'h02, 8'h01, 8'h77, 8'h88};
    model(s);
    feed(s, 0);
    drain();
    // unknown opcode then SET_ADDR with cmd_avail held high
    be = err_cnt;
    br = rd_cnt;
    s = '{8'h7F, 8'h01, 8'h05};
    model(s);
    feed(s, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("t3_err_pulses", err_cnt - be, 1);
    check("t3_rd_pulses", rd_cnt - br, 3);
    s = '{8'h02, 8'h01, 8'h00, 8'h01};
    model(s);
    feed(s, 0);
    drain();
    // stall between hi and lo bytes
    base = wr_cnt;
    model('{8'h02, 8'h01, 8'hAB, 8'hCD});
    feed('{8'h02, 8'h01, 8'hAB}, 0);
    g = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy && !lb_wr) g++;
    end
    check("t4_gap_cycles_busy_no_write", g, 20);
    feed('{8'hCD}, 0);
    drain();
    check("t4_write_count", wr_cnt - base, 1);
    // reset during the 10th word of a 100-word FILL
    mon_en = 1'b0;
    base = wr_cnt;
    feed('{8'h01, 8'h40, 8'h03, 8'h64, 8'h12, 8'h34}, 0);
    n = 0;
    while (wr_cnt - base < 10 && n < 500) begin @(negedge clk); #1; n++; end
    check("t5_reached_10th_write", wr_cnt - base, 10);
    check("t5_lb_wr_before_reset", lb_wr, 1);
    nrst = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(posedge clk); #1;
    nrst = 1'b1;
    prev_rd = 1'b0;
    exp_q.delete();
    m_addr = 0;
    mon_en = 1'b1;
    be = err_cnt;
    base = wr_cnt;
    feed('{8'h00}, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t5_nop_err", err_cnt - be, 0);
    check("t5_nop_writes", wr_cnt - base, 0);
    check("t5_nop_busy", busy, 0);
    s = '{8'h02, 8'h01, 8'hBE, 8'hEF};
    model(s);
    feed(s, 0);
    drain();
    // opcode 0x04: CLEAR when enabled, unknown otherwise
    s = '{8'h01, 8'h33, 8'h04};
    model(s);
    feed(s, 0);
    drain();
    check("t6_err_total", err_cnt, m_err);
    check("t6_busy_idle", busy, 0);
    // randomized packet mixes with random byte gaps
    for (int it = 0; it < 20; it++) begin
      s.delete();
      for (int p = 0; p < 4; p++) begin
        r = $urandom_range(4, 0);
        if (r == 0) s.push_back(8'h00);
        else if (r == 1) begin
          s.push_back(8'h01);
          s.push_back(8'($urandom));
        end else if (r == 2) begin
          n = $urandom_range(4, 1);
          s.push_back(8'h02);
          s.push_back(8'(n));
          repeat (2 * n) s.push_back(8'($urandom));
        end else if (r == 3) begin
          s.push_back(8'h03);
          s.push_back(8'($urandom_range(20, 1)));
          repeat (2) s.push_back(8'($urandom));
        end else s.push_back(8'($urandom_range(255, 5)));
      end
      model(s);
      feed(s, 3);
      drain();
      check("rand_err_total", err_cnt, m_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
- Command-stream parser between the shared command register (fed by the FIFO reader) and the line buffer block RAM write port.
- Consumes bytes from the shared register and decodes opcode/argument packets.
- Issues 16-bit word writes to the line buffer: address set, streamed word writes, and hardware fill.
- Replaces the ad-hoc one-byte-per-word command loop in the display top level.

Parameters:
ADDR_BITS, 8, line buffer word address width; addresses wrap modulo 2^ADDR_BITS
CLEAR_VALUE, 16'h0000, word written by CLEAR (optional feature only)

Ports:
clk  input  1  system clock (PLL clock on global buffer)
nrst  input  1  reset; asynchronous and active-low
cmd_avail  input  1  shared register has_data
cmd_data  input  8  shared register rd_data; valid while cmd_avail=1
cmd_rd  output  1  shared register rd strobe; one-cycle pulse per consumed byte
lb_wr  output  1  line buffer write enable (WCLKE)
lb_wr_addr  output  ADDR_BITS  line buffer write address
lb_wr_data  output  16  line buffer write data
busy  output  1  1 whenever state is not S_OP
err_op  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: asynchronous, nrst=0. Forces state=S_OP, cmd_rd=0, lb_wr=0, lb_wr_addr=0, lb_wr_data=0, busy=0, err_op=0, addr=0, count=0. Takes effect mid-packet or mid-fill; no partial write completes after nrst falls.
- All outputs are registered.
- Byte accept:
  - A byte is accepted in any cycle where the state needs a byte, cmd_avail=1, and cmd_rd=0.
  - On accept: cmd_data is sampled and cmd_rd=1 for the next cycle only.
  - cmd_rd is never high two consecutive cycles, so the maximum rate is 1 byte per 2 cycles.
- Opcodes (first byte of a packet, state S_OP):
  - 0x00 NOP: no effect; stay in S_OP.
  - 0x01 SET_ADDR: the next byte is loaded into addr.
  - 0x02 WRITE: next byte N (0 means 256), then N pairs hi, lo.
  - 0x03 FILL: next byte N (0 means 256), then pattern hi, lo; then N words written.
  - Any other value: err_op=1 for one cycle; byte discarded; stay in S_OP.
- States:
  - S_OP: wait for an opcode byte.
  - S_ADDR: accept byte -> addr; go to S_OP.
  - S_CNT: accept byte -> count (9-bit, 0 maps to 256); go to S_HI.
  - S_HI: accept byte -> hi register; go to S_LO.
  - S_LO: accept byte lo.
    - WRITE: next cycle lb_wr=1, lb_wr_data={hi,lo}, lb_wr_addr=addr. Then addr+1 and count-1; if count becomes 0 go to S_OP, else go to S_HI.
    - FILL: latch pattern {hi,lo}; go to S_FILL.
  - S_FILL: no bytes read. lb_wr=1 on each of N consecutive cycles, lb_wr_data=pattern, lb_wr_addr=addr, addr+1 per cycle. After the Nth write, lb_wr=0 and state is S_OP.
- Write timing: lb_wr is low in every cycle that does not carry a write. Write data and address are stable in any cycle where lb_wr=1.
- Latency: the lb_wr pulse for a WRITE word occurs 1 cycle after the lo byte is accepted. The first FILL write occurs 1 cycle after the pattern lo byte is accepted.
- Wrap: addr increments modulo 2^ADDR_BITS. After 0xFF comes 0x00; no error.
- cmd_avail=0 in any byte-wait state: hold the state indefinitely with no timeout.
- Addr persistence: addr carries across packets. It changes only via SET_ADDR, writes, or reset.

Optional Feature:
- Macro CMDDEC_CLEAR_EN.
- Defined: opcode 0x04 CLEAR, no arguments. Enters S_CLR and writes CLEAR_VALUE to addresses 0 through 2^ADDR_BITS-1, one word per cycle (256 consecutive lb_wr cycles at default). On exit addr=0, busy=0 and state is S_OP.
- Undefined: 0x04 is an unknown opcode (err_op pulse). S_CLR logic is absent.

Test Plan:
- Byte stream 01 10 02 02 AB CD 12 34 -> writes: addr 0x10 data 0xABCD, then addr 0x11 data 0x1234. Exactly 2 lb_wr pulses; busy=0 after the last write.
- Stream 01 FE 03 00 55 AA -> 256 consecutive lb_wr cycles of 0x55AA at addr FE, FF, 00 ... FD. Final addr=FE. No cmd_rd pulse during the fill.
- Stream 7F 01 05 with cmd_avail held 1 -> one err_op pulse; addr=0x05; cmd_rd pulses spaced ≥2 cycles apart; 3 pulses total.
- Drop nrst for 1 cycle during the 10th FILL write (N=100) -> lb_wr=0 immediately; all outputs reach reset values; next byte 00 is decoded as NOP.
- WRITE N=1 with cmd_avail low for 20 cycles between hi and lo -> busy=1 and no lb_wr throughout the gap. Single write once lo arrives.
- With CMDDEC_CLEAR_EN: 04 -> 256 writes of 0x0000 at addresses 0..FF in order. Without the macro: 04 -> err_op pulse and 0 writes.
